// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read data memory between the
// core load/store port (0) and a secondary master (1), with optional bus lock.
module dmem_arbiter #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned AWIDTH = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic              wen0,
    input  logic              wen1,
    input  logic [AWIDTH-1:0] addr0,
    input  logic [AWIDTH-1:0] addr1,
    input  logic [2:0]        width0,
    input  logic [2:0]        width1,
    input  logic [XLEN-1:0]   wdata0,
    input  logic [XLEN-1:0]   wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [XLEN-1:0]   rdata0,
    output logic [XLEN-1:0]   rdata1,
    output logic              mem_en,
    output logic              mem_wen,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [2:0]        mem_width,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t state, state_nxt;
    logic   last, last_nxt;
    logic   rd_pend, rd_port;
    logic   sel0, sel1;

    // Grant selection and ownership transitions
    always_comb begin
        sel0      = 1'b0;
        sel1      = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    sel0 = last;
                    sel1 = !last;
                end else begin
                    sel0 = req0;
                    sel1 = req1;
                end
                if (sel0 && lock0) begin
                    state_nxt = OWN0;
                end else if (sel1 && lock1) begin
                    state_nxt = OWN1;
                end
            end
            OWN0: begin
                sel0 = req0;
                if (!lock0) begin
                    state_nxt = IDLE;
                end
            end
            OWN1: begin
                sel1 = req1;
                if (!lock1) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grants are held low while reset is asserted so the memory sees no access
    assign gnt0 = sel0 && reset;
    assign gnt1 = sel1 && reset;

    always_comb begin
        last_nxt = last;
        if (gnt1) begin
            last_nxt = 1'b1;
        end else if (gnt0) begin
            last_nxt = 1'b0;
        end
    end

    always_comb begin
        mem_en    = gnt0 || gnt1;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_width = '0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_wen   = wen0;
            mem_addr  = addr0;
            mem_width = width0;
            mem_wdata = wdata0;
        end else if (gnt1) begin
            mem_wen   = wen1;
            mem_addr  = addr1;
            mem_width = width1;
            mem_wdata = wdata1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            last    <= 1'b1;
            rd_pend <= 1'b0;
            rd_port <= 1'b0;
        end else begin
            state   <= state_nxt;
            last    <= last_nxt;
            rd_pend <= mem_en && !mem_wen;
            rd_port <= gnt1;
        end
    end

    // Read data returns one cycle after the granted read, steered by rd_port
    assign rvalid0 = rd_pend && !rd_port;
    assign rvalid1 = rd_pend && rd_port;
    assign rdata0  = rvalid0 ? mem_rdata : '0;
    assign rdata1  = rvalid1 ? mem_rdata : '0;

endmodule
